// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse burst generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    GAP
  } state_t;

  localparam int SYNC_DEPTH   = 2;
  // Rising edges are suppressed until the synchroniser and edge history hold real samples.
  localparam int PRIME_CYCLES = SYNC_DEPTH + 1;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for the trigger level followed by a registered rising-edge detector.
module sync_edge_det
  import pulse_gen_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic trig,
  output logic trig_rise
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;
  logic [1:0]            prime_q;
  logic                  primed;

  assign primed = (prime_q == 2'(PRIME_CYCLES));

  // A level already high at reset release is not treated as an edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      prime_q   <= '0;
      trig_rise <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_DEPTH-2:0], trig};
      prev_q    <= sync_q[SYNC_DEPTH-1];
      trig_rise <= primed & sync_q[SYNC_DEPTH-1] & ~prev_q;
      if (!primed) prime_q <= prime_q + 2'd1;
    end
  end

endmodule

// File: rtl/pulse_burst_gen.sv
// Multi-channel pulse burst generator with shadowed configuration.
// Optional abort input enabled by defining PULSE_BURST_ABORT_EN.
module pulse_burst_gen
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 16,
  parameter int CNT_N_W = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               trig,
`ifdef PULSE_BURST_ABORT_EN
  input  logic               abort,
`endif
  input  logic [CNT_W-1:0]   cfg_width,
  input  logic [CNT_W-1:0]   cfg_gap,
  input  logic [CNT_N_W-1:0] cfg_count,
  input  logic [NUM_CH-1:0]  cfg_ch_en,
  input  logic [NUM_CH-1:0]  cfg_ch_inv,
  output logic [NUM_CH-1:0]  pulse_out,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               overrun
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     tcnt_q, tcnt_d;
  logic [CNT_N_W-1:0]   pcnt_q, pcnt_d;
  logic [CNT_W-1:0]     width_q, width_d, gap_q, gap_d;
  logic [CNT_N_W-1:0]   count_q, count_d;
  logic [NUM_CH-1:0]    en_q, en_d, inv_q, inv_d;
  logic [NUM_CH-1:0]    out_d;
  logic                 done_d, err_d, overrun_d;
  logic                 trig_rise;
  logic                 abort_req;

  sync_edge_det u_sync_edge_det (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .trig      (trig),
    .trig_rise (trig_rise)
  );

`ifdef PULSE_BURST_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    pcnt_d    = pcnt_q;
    width_d   = width_q;
    gap_d     = gap_q;
    count_d   = count_q;
    en_d      = en_q;
    inv_d     = inv_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    overrun_d = overrun | (trig_rise & (state_q != IDLE));
    out_d     = cfg_ch_inv;

    case (state_q)
      IDLE: begin
        if (trig_rise) begin
          if (cfg_width == '0 || cfg_count == '0) begin
            err_d = 1'b1;
          end else begin
            width_d = cfg_width;
            gap_d   = cfg_gap;
            count_d = cfg_count;
            en_d    = cfg_ch_en;
            inv_d   = cfg_ch_inv;
            state_d = HIGH;
            tcnt_d  = cfg_width - 1'b1;
            pcnt_d  = CNT_N_W'(1);
          end
        end
      end
      HIGH: begin
        if (tcnt_q == '0) begin
          if (pcnt_q == count_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // A zero gap still leaves one inactive cycle between pulses.
            state_d = GAP;
            tcnt_d  = (gap_q == '0) ? '0 : gap_q - 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      GAP: begin
        if (tcnt_q == '0) begin
          state_d = HIGH;
          tcnt_d  = width_q - 1'b1;
          pcnt_d  = pcnt_q + 1'b1;
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_req && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
      tcnt_d  = '0;
      pcnt_d  = '0;
    end

    // Outputs are computed from the next state so pulse_out comes straight from flops.
    case (state_d)
      HIGH:    out_d = inv_d ^ en_d;
      GAP:     out_d = inv_d;
      default: out_d = cfg_ch_inv;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      pcnt_q    <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      count_q   <= '0;
      en_q      <= '0;
      inv_q     <= '0;
      pulse_out <= '0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      pcnt_q    <= pcnt_d;
      width_q   <= width_d;
      gap_q     <= gap_d;
      count_q   <= count_d;
      en_q      <= en_d;
      inv_q     <= inv_d;
      pulse_out <= out_d;
      done      <= done_d;
      cfg_err   <= err_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Self-checking bench for pulse_burst_gen: directed scenarios plus random bursts against a timeline model.
module tb_pulse_burst_gen;

  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 16;
  localparam int CNT_N_W = 4;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n;
  logic               trig;
  logic               abort;
  logic [CNT_W-1:0]   cfg_width;
  logic [CNT_W-1:0]   cfg_gap;
  logic [CNT_N_W-1:0] cfg_count;
  logic [NUM_CH-1:0]  cfg_ch_en;
  logic [NUM_CH-1:0]  cfg_ch_inv;
  logic [NUM_CH-1:0]  pulse_out;
  logic               busy, done, cfg_err, overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          rise_q[$];
  bit          m_busy, m_done, m_err, m_ovr;
  int          m_t;
  int          sh_w, sh_g, sh_c;
  logic [1:0]  sh_en, sh_inv, exp_out;

  int busy_cycles, done_seen, err_seen, ch1_low;

  always #5 sys_clk = ~sys_clk;

  pulse_burst_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CNT_N_W(CNT_N_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .trig       (trig),
`ifdef PULSE_BURST_ABORT_EN
    .abort      (abort),
`endif
    .cfg_width  (cfg_width),
    .cfg_gap    (cfg_gap),
    .cfg_count  (cfg_count),
    .cfg_ch_en  (cfg_ch_en),
    .cfg_ch_inv (cfg_ch_inv),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .overrun    (overrun)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  // Burst timeline: pulse k occupies [k*(w+g'), k*(w+g')+w), total length c*w+(c-1)*g'.
  task automatic model_edge();
    bit rise = 0;
    bit was_busy;
    int gp, len;
    if (!sys_rst_n) return;
    if (rise_q.size() > 0 && rise_q[0] == cyc) begin
      rise = 1;
      void'(rise_q.pop_front());
    end
    was_busy = m_busy;
    m_done = 0;
    m_err  = 0;
    gp  = (sh_g == 0) ? 1 : sh_g;
    len = sh_c * sh_w + (sh_c - 1) * gp;
    if (was_busy) begin
      if (abort === 1'b1) m_busy = 0;
      else begin
        m_t++;
        if (m_t == len) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
    if (rise) begin
      if (was_busy) m_ovr = 1;
      else if (cfg_width == 0 || cfg_count == 0) m_err = 1;
      else begin
        sh_w = int'(cfg_width); sh_g = int'(cfg_gap); sh_c = int'(cfg_count);
        sh_en = cfg_ch_en; sh_inv = cfg_ch_inv;
        m_busy = 1;
        m_t = 0;
      end
    end
    if (m_busy) begin
      gp = (sh_g == 0) ? 1 : sh_g;
      exp_out = ((m_t % (sh_w + gp)) < sh_w) ? (sh_inv ^ sh_en) : sh_inv;
    end else begin
      exp_out = cfg_ch_inv;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    cyc++;
    model_edge();
    @(negedge sys_clk);
    check_output("pulse_out", 32'(pulse_out), 32'(exp_out));
    check_output("busy",      32'(busy),      32'(m_busy));
    check_output("done",      32'(done),      32'(m_done));
    check_output("cfg_err",   32'(cfg_err),   32'(m_err));
    check_output("overrun",   32'(overrun),   32'(m_ovr));
    if (busy === 1'b1) busy_cycles++;
    if (done === 1'b1) done_seen++;
    if (cfg_err === 1'b1) err_seen++;
    if (pulse_out[1] !== 1'b1) ch1_low++;
  endtask

  task automatic set_trig(input logic v);
    if (v && !trig && sys_rst_n) rise_q.push_back(cyc + 4);
    trig = v;
  endtask

  task automatic fire_trigger();
    set_trig(1'b1);
    repeat (3) tick();
    set_trig(1'b0);
    repeat (3) tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || rise_q.size() > 0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("[TB] FAIL wait_idle observed=timeout expected=idle cycle=%0d", cyc);
    end
    repeat (2) tick();
  endtask

  task automatic clear_stats();
    busy_cycles = 0; done_seen = 0; err_seen = 0; ch1_low = 0;
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    #1;
    check_output("rst_pulse_out", 32'(pulse_out), 32'd0);
    check_output("rst_busy",      32'(busy),      32'd0);
    check_output("rst_done",      32'(done),      32'd0);
    check_output("rst_cfg_err",   32'(cfg_err),   32'd0);
    check_output("rst_overrun",   32'(overrun),   32'd0);
    m_busy = 0; m_done = 0; m_err = 0; m_ovr = 0; m_t = 0;
    sh_w = 0; sh_g = 0; sh_c = 0; sh_en = '0; sh_inv = '0; exp_out = '0;
    rise_q.delete();
    repeat (2) tick();
    sys_rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic apply_stimulus(input int w, input int g, input int c, input logic [1:0] en, input logic [1:0] inv);
    cfg_width  = CNT_W'(w);
    cfg_gap    = CNT_W'(g);
    cfg_count  = CNT_N_W'(c);
    cfg_ch_en  = en;
    cfg_ch_inv = inv;
  endtask

  initial begin
    trig = 1'b0;
    abort = 1'b0;
    apply_stimulus(1, 1, 1, 2'b00, 2'b00);
    clear_stats();
    apply_reset();

    $display("[TB] basic burst w=5 g=3 c=3");
    apply_stimulus(5, 3, 3, 2'b11, 2'b00);
    clear_stats();
    fire_trigger();
    wait_idle();
    check_output("basic_busy_len", 32'(busy_cycles), 32'd21);
    check_output("basic_done_cnt", 32'(done_seen),   32'd1);

    $display("[TB] zero gap w=4 g=0 c=2");
    apply_stimulus(4, 0, 2, 2'b11, 2'b00);
    clear_stats();
    fire_trigger();
    wait_idle();
    check_output("gap0_busy_len", 32'(busy_cycles), 32'd9);
    check_output("gap0_done_cnt", 32'(done_seen),   32'd1);

    $display("[TB] enable/invert en=01 inv=10");
    apply_stimulus(3, 2, 2, 2'b01, 2'b10);
    clear_stats();
    fire_trigger();
    wait_idle();
    check_output("ch1_held_high", 32'(ch1_low), 32'd0);

    $display("[TB] illegal count then legal trigger");
    apply_stimulus(3, 1, 0, 2'b11, 2'b00);
    clear_stats();
    fire_trigger();
    wait_idle();
    check_output("illegal_err_cnt",  32'(err_seen),    32'd1);
    check_output("illegal_busy_len", 32'(busy_cycles), 32'd0);
    apply_stimulus(2, 1, 2, 2'b11, 2'b01);
    clear_stats();
    fire_trigger();
    wait_idle();
    check_output("legal_after_err_busy", 32'(busy_cycles), 32'd5);

    $display("[TB] retrigger and config change mid-burst");
    apply_stimulus(6, 2, 3, 2'b11, 2'b00);
    clear_stats();
    fire_trigger();
    repeat (4) tick();
    cfg_width = 16'd2;
    fire_trigger();
    wait_idle();
    check_output("mid_busy_len", 32'(busy_cycles), 32'd22);
    check_output("mid_overrun",  32'(overrun),     32'd1);

    $display("[TB] reset mid-HIGH");
    apply_stimulus(8, 1, 2, 2'b11, 2'b00);
    fire_trigger();
    repeat (2) tick();
    apply_reset();

    $display("[TB] trigger held high across reset release");
    sys_rst_n = 1'b0;
    set_trig(1'b1);
    apply_reset();
    clear_stats();
    repeat (8) tick();
    check_output("no_spurious_busy", 32'(busy_cycles), 32'd0);
    set_trig(1'b0);
    repeat (4) tick();

`ifdef PULSE_BURST_ABORT_EN
    $display("[TB] abort in second gap");
    apply_stimulus(3, 2, 4, 2'b11, 2'b00);
    clear_stats();
    fire_trigger();
    while (!(m_busy && m_t == 8) && cyc < 5000) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle();
    check_output("abort_done_cnt", 32'(done_seen), 32'd0);
    check_output("abort_busy_len", 32'(busy_cycles), 32'd9);
    clear_stats();
    fire_trigger();
    wait_idle();
    check_output("after_abort_done", 32'(done_seen), 32'd1);
`endif

    $display("[TB] random bursts");
    for (int k = 0; k < 16; k++) begin
      apply_stimulus(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)),
                     int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                     2'($urandom), 2'($urandom));
      fire_trigger();
      if ($urandom_range(0, 3) == 0) fire_trigger();
      repeat ($urandom_range(0, 4)) tick();
      cfg_ch_inv = 2'($urandom);
      cfg_width  = CNT_W'($urandom_range(0, 6));
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_burst_gen.md
PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of output channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of width/gap fields and timing counter.
REQ-003 SHALL have parameter CNT_N_W, default 4, width of burst pulse-count field.
REQ-004 SHALL have port sys_clk  input  1  clock; all logic is synchronous to it, with no internal PLL.
REQ-005 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port trig  input  1  asynchronous trigger level; a rising edge starts a burst.
REQ-007 SHALL have port cfg_width  input  CNT_W  high time of each pulse, in sys_clk cycles.
REQ-008 SHALL have port cfg_gap  input  CNT_W  low time between pulses, in cycles.
REQ-009 SHALL have port cfg_count  input  CNT_N_W  number of pulses per burst.
REQ-010 SHALL have port cfg_ch_en  input  NUM_CH  per-channel output enable.
REQ-011 SHALL have port cfg_ch_inv  input  NUM_CH  per-channel output polarity inversion.
REQ-012 SHALL have port pulse_out  output  NUM_CH  registered pulse outputs.
REQ-013 SHALL have port busy  output  1  high while a burst is in progress.
REQ-014 SHALL have port done  output  1  one-cycle strobe when a burst completes normally.
REQ-015 SHALL have port cfg_err  output  1  one-cycle strobe when a trigger is rejected for an illegal config.
REQ-016 SHALL have port overrun  output  1  sticky flag, set by a trigger edge seen while busy.

Function
REQ-017 SHALL pass trig through a 2-flop synchroniser, then a rising-edge detector; trig_rise asserts one cycle, 3 cycles after the trig edge.
REQ-018 SHALL implement the FSM IDLE -> HIGH -> GAP -> HIGH ... -> IDLE.
REQ-019 SHALL, on trig_rise in IDLE, latch all cfg_* inputs into shadow registers; later cfg changes do not affect the running burst.
REQ-020 SHALL, on trig_rise in IDLE, treat cfg_width==0 or cfg_count==0 as illegal: assert cfg_err, stay IDLE, outputs unchanged.
REQ-021 SHALL, on a legal trigger, enter HIGH on the next cycle with the pulse counter at 1 and busy=1.
REQ-022 SHALL keep HIGH for exactly width cycles; the active level of channel i is en[i] ? ~inv[i] : inv[i]... for disabled channels the output SHALL be held at the inactive level inv[i].
REQ-023 SHALL, after HIGH, go to GAP for exactly gap cycles if pulses issued < count; if gap==0, SHALL go HIGH->HIGH with a single inactive cycle (minimum gap 1).
REQ-024 SHALL, when pulses issued == count at the end of HIGH, return to IDLE, deassert busy and pulse done for one cycle in that same transition cycle.
REQ-025 SHALL, in IDLE, drive every pulse_out[i] at its inactive level inv[i], using live cfg_ch_inv.
REQ-026 SHALL ignore trig_rise while busy and set overrun; overrun clears only on reset.
REQ-027 SHALL implement the timing counter as a down-counter of CNT_W bits; width=2^CNT_W-1 SHALL be honoured without wrap.
REQ-028 SHALL register pulse_out directly from flops, with no combinational path from inputs.

Reset
REQ-029 SHALL, on sys_rst_n low at any time (including mid-burst), asynchronously force FSM=IDLE, counters=0, shadows=0, busy=0, done=0, cfg_err=0, overrun=0, synchroniser=0, and pulse_out=0.
REQ-030 SHALL not produce a spurious trig_rise after reset release while trig is held high; the synchroniser resets to 0 and the edge detector is primed from the first two sampled cycles.

Configuration
REQ-031 SHALL, with PULSE_BURST_ABORT_EN defined, add input abort (1 bit, synchronous, active-high); abort while busy SHALL return to IDLE next cycle with outputs inactive, no done strobe, and abort taking priority over all transitions.
REQ-032 SHALL, without PULSE_BURST_ABORT_EN, have no abort port, and a burst always runs to completion or reset.

Structure
REQ-033 SHALL place the state enum typedef (IDLE, HIGH, GAP) and the synchroniser depth constant (2) in package pulse_gen_pkg.
REQ-034 SHALL use one sub-module, sync_edge_det (synchroniser plus rising-edge detector), instantiated once.

Verification
REQ-035 SHALL cover: width=5, gap=3, count=3, en=2'b11, inv=0 -> three 5-cycle highs separated by 3-cycle lows, done once, busy for 21 cycles.
REQ-036 SHALL cover: width=4, gap=0, count=2 -> 4 high, 1 low, 4 high, then done.
REQ-037 SHALL cover: en=2'b01, inv=2'b10 -> ch0 pulses, ch1 held constant 1 throughout.
REQ-038 SHALL cover: cfg_count=0 with a trigger -> cfg_err one cycle, busy stays 0, no pulses; then a legal trigger runs normally.
REQ-039 SHALL cover: a second trig edge mid-burst, plus cfg_width changed mid-burst -> burst unaffected and overrun=1; reset mid-HIGH -> all outputs 0 immediately.
REQ-040 SHALL cover, with PULSE_BURST_ABORT_EN: abort in the 2nd GAP of count=4 -> IDLE next cycle, no done, with a new trigger accepted afterwards.
